logic_test_unit: RTL and testbench



---
 rtl/logic_test_pkg.sv | 9 +
 rtl/lt_bitwise_core.sv | 21 ++
 rtl/logic_test_unit.sv | 50 +++++
 tb/tb_logic_test_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/logic_test_pkg.sv
// Shared definitions for the logic-test bitwise unit and its reference users.
package logic_test_pkg;

  localparam int LT_WIDTH_DEFAULT = 4;

  // Operand/result vector at the default width.
  typedef logic [LT_WIDTH_DEFAULT-1:0] lt_operand_t;

endpackage

// File: rtl/lt_bitwise_core.sv
// Purely combinational bitwise core: AND, OR, XOR of A/B and inverse of A.
// Each result bit depends only on the same bit position of the operands.
module lt_bitwise_core
  import logic_test_pkg::*;
#(
  parameter int WIDTH = LT_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_res,
  output logic [WIDTH-1:0] or_res,
  output logic [WIDTH-1:0] not_res,
  output logic [WIDTH-1:0] xor_res
);

  assign and_res = a & b;
  assign or_res  = a | b;
  assign not_res = ~a;   // B intentionally has no influence here
  assign xor_res = a ^ b;

endmodule

// File: rtl/logic_test_unit.sv
// Registered bitwise logic unit: combinational core followed by one bank of
// four output registers. Reset clears all outputs to zero (including NOT),
// asynchronously, and the first edge after release loads the live inputs.
module logic_test_unit
  import logic_test_pkg::*;
#(
  parameter int WIDTH = LT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] LT_i_0,
  input  logic [WIDTH-1:0] LT_i_1,
  output logic [WIDTH-1:0] LT_o_AND,
  output logic [WIDTH-1:0] LT_o_OR,
  output logic [WIDTH-1:0] LT_o_NOT,
  output logic [WIDTH-1:0] LT_o_XOR
);

  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] or_res;
  logic [WIDTH-1:0] not_res;
  logic [WIDTH-1:0] xor_res;

  lt_bitwise_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (LT_i_0),
    .b      (LT_i_1),
    .and_res(and_res),
    .or_res (or_res),
    .not_res(not_res),
    .xor_res(xor_res)
  );

  // Output bank: all four results captured on the same edge, cleared together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LT_o_AND <= '0;
      LT_o_OR  <= '0;
      LT_o_NOT <= '0;
      LT_o_XOR <= '0;
    end else begin
      LT_o_AND <= and_res;
      LT_o_OR  <= or_res;
      LT_o_NOT <= not_res;
      LT_o_XOR <= xor_res;
    end
  end

endmodule

// File: tb/tb_logic_test_unit.sv
// Self-checking bench for logic_test_unit at WIDTH=4, 1 and 32.
module tb_logic_test_unit;
  import logic_test_pkg::*;

  typedef struct {
    lt_operand_t a;
    lt_operand_t b;
    lt_operand_t e_and;
    lt_operand_t e_or;
    lt_operand_t e_not;
    lt_operand_t e_xor;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  lt_operand_t a4, b4;
  lt_operand_t and4, or4, not4, xor4;
  logic [0:0]  a1, b1, and1, or1, not1, xor1;
  logic [31:0] a32, b32, and32, or32, not32, xor32;

  int checks = 0;
  int errors = 0;

  vec_t dir_vecs[5];
  vec_t btb_vecs[5];

  logic_test_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .LT_i_0(a4), .LT_i_1(b4),
    .LT_o_AND(and4), .LT_o_OR(or4), .LT_o_NOT(not4), .LT_o_XOR(xor4)
  );

  logic_test_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .LT_i_0(a1), .LT_i_1(b1),
    .LT_o_AND(and1), .LT_o_OR(or1), .LT_o_NOT(not1), .LT_o_XOR(xor1)
  );

  logic_test_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .LT_i_0(a32), .LT_i_1(b32),
    .LT_o_AND(and32), .LT_o_OR(or32), .LT_o_NOT(not32), .LT_o_XOR(xor32)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check4(input string tag, input lt_operand_t ea, input lt_operand_t eo,
                        input lt_operand_t en, input lt_operand_t ex);
    check({tag, "_and"}, {28'd0, and4}, {28'd0, ea});
    check({tag, "_or"},  {28'd0, or4},  {28'd0, eo});
    check({tag, "_not"}, {28'd0, not4}, {28'd0, en});
    check({tag, "_xor"}, {28'd0, xor4}, {28'd0, ex});
  endtask

  task automatic apply4(input lt_operand_t a, input lt_operand_t b);
    a4 = a;
    b4 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lt_operand_t ea, eo, en, ex;
    logic [0:0]  e1a, e1o, e1n, e1x;
    logic [31:0] e32;

    dir_vecs[0] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b1111, 4'b0001};
    dir_vecs[1] = '{4'b1111, 4'b1000, 4'b1000, 4'b1111, 4'b0000, 4'b0111};
    dir_vecs[2] = '{4'b0101, 4'b0010, 4'b0000, 4'b0111, 4'b1010, 4'b0111};
    dir_vecs[3] = '{4'b1110, 4'b1100, 4'b1100, 4'b1110, 4'b0001, 4'b0010};
    dir_vecs[4] = '{4'b1011, 4'b0010, 4'b0010, 4'b1011, 4'b0100, 4'b1001};

    btb_vecs[0] = '{4'b0010, 4'b1001, 4'b0000, 4'b1011, 4'b1101, 4'b1011};
    btb_vecs[1] = '{4'b0011, 4'b1100, 4'b0000, 4'b1111, 4'b1100, 4'b1111};
    btb_vecs[2] = '{4'b1110, 4'b0001, 4'b0000, 4'b1111, 4'b0001, 4'b1111};
    btb_vecs[3] = '{4'b0000, 4'b1011, 4'b0000, 4'b1011, 4'b1111, 4'b1011};
    btb_vecs[4] = '{4'b1100, 4'b0010, 4'b0000, 4'b1110, 4'b0011, 4'b1110};

    // Reset with no clock edge yet (first posedge at t=5).
    rst = 1'b1;
    a4 = 4'b1111; b4 = 4'b1111;
    a1 = 1'b1; b1 = 1'b1;
    a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
    #1;
    check4("reset_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("reset_w1_not", {31'd0, not1}, 32'd0);
    check("reset_w32_or", or32, 32'd0);
    check("reset_w32_not", not32, 32'd0);

    #1 rst = 1'b0;
    #1;
    check4("released_no_edge", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    check4("first_edge", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    check("first_edge_w32_and", and32, 32'hFFFF_FFFF);

    // Directed vectors, plus a mid-cycle input change that must not leak.
    for (int i = 0; i < 5; i++) begin
      apply4(dir_vecs[i].a, dir_vecs[i].b);
      check4($sformatf("dir%0d", i), dir_vecs[i].e_and, dir_vecs[i].e_or,
             dir_vecs[i].e_not, dir_vecs[i].e_xor);
      a4 = ~dir_vecs[i].a;
      b4 = ~dir_vecs[i].b;
      #2;
      check4($sformatf("dir%0d_hold", i), dir_vecs[i].e_and, dir_vecs[i].e_or,
             dir_vecs[i].e_not, dir_vecs[i].e_xor);
    end

    // NOT must ignore B.
    for (int b = 0; b < 16; b++) begin
      apply4(4'b0011, lt_operand_t'(b));
      check($sformatf("not_b_indep_%0d", b), {28'd0, not4}, 32'h0000_000C);
    end

    // Back-to-back changes every cycle.
    for (int i = 0; i < 5; i++) begin
      apply4(btb_vecs[i].a, btb_vecs[i].b);
      check4($sformatf("btb%0d", i), btb_vecs[i].e_and, btb_vecs[i].e_or,
             btb_vecs[i].e_not, btb_vecs[i].e_xor);
    end

    // Back-to-back with a reset pulse between edges.
    apply4(btb_vecs[0].a, btb_vecs[0].b);
    check4("mid_pre", btb_vecs[0].e_and, btb_vecs[0].e_or, btb_vecs[0].e_not, btb_vecs[0].e_xor);
    a4 = btb_vecs[1].a;
    b4 = btb_vecs[1].b;
    #1 rst = 1'b1;
    #1;
    check4("mid_rst_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    #1;
    check4("mid_rst_released", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    check4("mid_resume1", btb_vecs[1].e_and, btb_vecs[1].e_or, btb_vecs[1].e_not, btb_vecs[1].e_xor);
    for (int i = 2; i < 5; i++) begin
      apply4(btb_vecs[i].a, btb_vecs[i].b);
      check4($sformatf("mid_resume%0d", i), btb_vecs[i].e_and, btb_vecs[i].e_or,
             btb_vecs[i].e_not, btb_vecs[i].e_xor);
    end

    // Exhaustive WIDTH=4.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        apply4(lt_operand_t'(a), lt_operand_t'(b));
        ea = lt_operand_t'(a) & lt_operand_t'(b);
        eo = lt_operand_t'(a) | lt_operand_t'(b);
        en = ~lt_operand_t'(a);
        ex = lt_operand_t'(a) ^ lt_operand_t'(b);
        check4($sformatf("exh_%0d_%0d", a, b), ea, eo, en, ex);
      end
    end

    // Random WIDTH=1 and WIDTH=32.
    for (int i = 0; i < 48; i++) begin
      a1  = 1'($urandom);
      b1  = 1'($urandom);
      a32 = $urandom;
      b32 = $urandom;
      @(posedge clk);
      #1;
      e1a = a1 & b1;
      e1o = a1 | b1;
      e1n = ~a1;
      e1x = a1 ^ b1;
      check($sformatf("w1_and_%0d", i), {31'd0, and1}, {31'd0, e1a});
      check($sformatf("w1_or_%0d", i),  {31'd0, or1},  {31'd0, e1o});
      check($sformatf("w1_not_%0d", i), {31'd0, not1}, {31'd0, e1n});
      check($sformatf("w1_xor_%0d", i), {31'd0, xor1}, {31'd0, e1x});
      e32 = a32 & b32;
      check($sformatf("w32_and_%0d", i), and32, e32);
      e32 = a32 | b32;
      check($sformatf("w32_or_%0d", i), or32, e32);
      e32 = ~a32;
      check($sformatf("w32_not_%0d", i), not32, e32);
      e32 = a32 ^ b32;
      check($sformatf("w32_xor_%0d", i), xor32, e32);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
